mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one synchronous single-port memory between
// instruction fetch (IF) and load/store (LS). Grants are combinational and
// round-robin on conflict; read responses come back one cycle later and are
// steered by a small response-phase state register.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_LS = 2'd2,
        WR    = 2'd3
    } state_t;

    typedef enum logic {
        WIN_IF = 1'b0,
        WIN_LS = 1'b1
    } winner_t;

    state_t  state, state_next;
    winner_t last_winner, last_winner_next;
    logic    flush_q, flush_next;
    logic    conflict;

    // Response-phase state, round-robin history and dropped-fetch flag.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= WIN_LS;   // IF wins the first conflict after reset
            flush_q     <= 1'b0;
        end else begin
            state       <= state_next;
            last_winner <= last_winner_next;
            flush_q     <= flush_next;
        end
    end

    // Grant selection, memory strobe, next state and response steering.
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned; a missing default in always_comb infers a latch.
    always_comb begin
        if_gnt           = 1'b0;
        ls_gnt           = 1'b0;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        if_rvalid        = 1'b0;
        if_rdata         = '0;
        ls_rvalid        = 1'b0;
        ls_rdata         = '0;
        conflict         = 1'b0;
        state_next       = IDLE;
        last_winner_next = last_winner;
        flush_next       = 1'b0;

        // NOTE: outputs are gated by rst_n as well as the registers being
        // reset, so nothing leaks out while reset is held with live requests.
        if (rst_n) begin
            conflict = if_req && ls_req;
            if_gnt   = if_req && (!ls_req || (last_winner == WIN_LS));
            ls_gnt   = ls_req && !if_gnt;

            if (conflict) begin
                last_winner_next = if_gnt ? WIN_IF : WIN_LS;
            end

            if (if_gnt) begin
                mem_en     = 1'b1;
                mem_addr   = if_addr;
                mem_wdata  = ls_wdata;
                state_next = RD_IF;
                flush_next = if_flush;   // response already doomed
            end else if (ls_gnt) begin
                mem_en     = 1'b1;
                mem_we     = ls_we;
                mem_addr   = ls_addr;
                mem_wdata  = ls_wdata;
                state_next = ls_we ? WR : RD_LS;
            end

            // Fetch response survives only if not flushed at grant or now.
            if (state == RD_IF && !flush_q && !if_flush) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end

            if (state == RD_LS) begin
                ls_rvalid = 1'b1;
                ls_rdata  = mem_rdata;
            end
        end
    end

endmodule
